// File: rtl/t_ff_bank_counter.sv
// rtl/t_ff_bank_counter.sv - WIDTH-bit toggle bank / modulo up-down counter / loadable register
// Four run-time modes on one clock, with a terminal-count flag and a registered wrap pulse.
module t_ff_bank_counter #(
  parameter int unsigned      WIDTH    = 4,
  parameter longint unsigned  MODULUS  = 16,
  parameter bit               SATURATE = 1'b0,
  parameter logic [WIDTH-1:0] RST_VAL  = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] t,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap
);

  localparam logic [1:0] MODE_TOGGLE = 2'b00;
  localparam logic [1:0] MODE_UP     = 2'b01;
  localparam logic [1:0] MODE_DOWN   = 2'b10;
  localparam logic [1:0] MODE_LOAD   = 2'b11;

  // Top of the count range; MODULUS may be 2**WIDTH, so it is held as a 64-bit value.
  localparam logic [WIDTH-1:0] TOP = WIDTH'(MODULUS - 64'd1);

  logic at_top;
  logic at_zero;

  assign at_top  = (q >= TOP);
  assign at_zero = (q == '0);

  always_comb begin
    tc = en & (((mode == MODE_UP) & at_top) | ((mode == MODE_DOWN) & at_zero));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q    <= RST_VAL;
      wrap <= 1'b0;
    end else if (!en) begin
      wrap <= 1'b0;
    end else begin
      wrap <= 1'b0;
      case (mode)
        MODE_TOGGLE: q <= q ^ t;
        MODE_UP: begin
          if (at_top) begin
            q    <= SATURATE ? TOP : '0;
            wrap <= !SATURATE;
          end else begin
            q <= q + WIDTH'(1);
          end
        end
        MODE_DOWN: begin
          if (at_zero) begin
            q    <= SATURATE ? '0 : TOP;
            wrap <= !SATURATE;
          end else if (q > TOP) begin
            // Out-of-range values (from toggle or load) clamp to the top without a wrap.
            q <= TOP;
          end else begin
            q <= q - WIDTH'(1);
          end
        end
        MODE_LOAD: q <= d;
        default:   q <= q;
      endcase
    end
  end

endmodule

// File: tb/tb_t_ff_bank_counter.sv
// tb/tb_t_ff_bank_counter.sv - bench for t_ff_bank_counter across wrap, saturate, reset-value and full-range builds
module tb_t_ff_bank_counter;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [3:0] t = 4'd0;
  logic [3:0] d = 4'd0;

  logic [3:0] dq  [N];
  logic       dtc [N];
  logic       dwr [N];

  int modv [N] = '{10, 10, 10, 16};
  int satv [N] = '{0, 1, 0, 0};
  int rstv [N] = '{0, 0, 5, 0};

  int mq [N];
  int mw [N];
  bit valid = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  t_ff_bank_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0), .RST_VAL(4'd0)) u_wrap (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .t(t), .d(d),
    .q(dq[0]), .tc(dtc[0]), .wrap(dwr[0]));

  t_ff_bank_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b1), .RST_VAL(4'd0)) u_sat (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .t(t), .d(d),
    .q(dq[1]), .tc(dtc[1]), .wrap(dwr[1]));

  t_ff_bank_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0), .RST_VAL(4'd5)) u_rv5 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .t(t), .d(d),
    .q(dq[2]), .tc(dtc[2]), .wrap(dwr[2]));

  t_ff_bank_counter #(.WIDTH(4), .MODULUS(16), .SATURATE(1'b0), .RST_VAL(4'd0)) u_full (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .t(t), .d(d),
    .q(dq[3]), .tc(dtc[3]), .wrap(dwr[3]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Next state straight from the mode rules, in plain integers.
  task automatic model_edge(input int i);
    int top;
    top = modv[i] - 1;
    mw[i] = 0;
    if (rst) begin
      mq[i] = rstv[i];
    end else if (en) begin
      case (mode)
        2'b00: mq[i] = mq[i] ^ int'(t);
        2'b01: begin
          if (mq[i] >= top) begin
            mq[i] = satv[i] ? top : 0;
            mw[i] = !satv[i];
          end else mq[i] = mq[i] + 1;
        end
        2'b10: begin
          if (mq[i] == 0) begin
            mq[i] = satv[i] ? 0 : top;
            mw[i] = !satv[i];
          end else if (mq[i] > top) mq[i] = top;
          else mq[i] = mq[i] - 1;
        end
        default: mq[i] = int'(d);
      endcase
    end
  endtask

  task automatic step(input bit r, input bit e, input logic [1:0] m,
                      input logic [3:0] tt, input logic [3:0] dd);
    int exp_tc;
    @(negedge clk);
    rst = r; en = e; mode = m; t = tt; d = dd;
    #1;
    if (valid) begin
      for (int i = 0; i < N; i++) begin
        exp_tc = (en && ((mode == 2'b01 && mq[i] >= modv[i] - 1) || (mode == 2'b10 && mq[i] == 0))) ? 1 : 0;
        chk($sformatf("tc[%0d] q=%0d mode=%0d", i, mq[i], mode), 32'(dtc[i]), 32'(exp_tc));
      end
    end
    @(posedge clk);
    for (int i = 0; i < N; i++) model_edge(i);
    valid = 1'b1;
    #1;
    for (int i = 0; i < N; i++) begin
      chk($sformatf("q[%0d]", i), 32'(dq[i]), 32'(mq[i]));
      chk($sformatf("wrap[%0d]", i), 32'(dwr[i]), 32'(mw[i]));
    end
  endtask

  initial begin
    // reset held with counting requested
    step(1, 1, 2'b01, 4'd0, 4'd0);
    step(1, 1, 2'b01, 4'd0, 4'd0);
    // up count with an enable gap mid-run
    repeat (5) step(0, 1, 2'b01, 4'd0, 4'd0);
    repeat (3) step(0, 0, 2'b01, 4'd0, 4'd0);
    repeat (8) step(0, 1, 2'b01, 4'd0, 4'd0);
    // toggle bank
    step(0, 1, 2'b11, 4'd0, 4'b0101);
    step(0, 1, 2'b00, 4'b0011, 4'd0);
    step(0, 1, 2'b00, 4'b0000, 4'd0);
    step(0, 0, 2'b00, 4'b1111, 4'd0);
    step(0, 1, 2'b00, 4'b1111, 4'd0);
    // down count through zero
    step(0, 1, 2'b11, 4'd0, 4'd0);
    repeat (4) step(0, 1, 2'b10, 4'd0, 4'd0);
    // out-of-range load then count
    step(0, 1, 2'b11, 4'd0, 4'b1100);
    step(0, 1, 2'b01, 4'd0, 4'd0);
    step(0, 1, 2'b11, 4'd0, 4'b1100);
    step(0, 1, 2'b10, 4'd0, 4'd0);
    // full-range wrap and reset mid-count
    step(0, 1, 2'b11, 4'd0, 4'b1111);
    step(0, 1, 2'b01, 4'd0, 4'd0);
    step(0, 1, 2'b11, 4'd0, 4'd6);
    step(0, 1, 2'b01, 4'd0, 4'd0);
    step(1, 1, 2'b11, 4'd0, 4'b0011);
    step(0, 1, 2'b01, 4'd0, 4'd0);
    // randomized traffic with rare resets
    for (int k = 0; k < 400; k++) begin
      step(($urandom_range(0, 39) == 0), ($urandom_range(0, 4) != 0),
           2'($urandom_range(0, 3)), 4'($urandom), 4'($urandom));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
